// File: rtl/apb_fll_if_pkg.sv
// apb_fll_if_pkg: shared types, address offsets and STATUS bit positions for apb_fll_if
package apb_fll_if_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
    localparam logic [4:0] FLL_REG0   = 5'h00;
    localparam logic [4:0] FLL_REG1   = 5'h04;
    localparam logic [4:0] FLL_REG2   = 5'h08;
    localparam logic [4:0] FLL_REG3   = 5'h0C;
    localparam logic [4:0] FLL_STATUS = 5'h10;
    localparam int STATUS_LOCK      = 0;
    localparam int STATUS_LOCK_LOST = 1;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level
// ports: clk_i clock, rstn_i async active-low reset, d async input, q synchronized output
module sync_2ff (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) {q, m} <= '0;
        else         {q, m} <= {m, d};
endmodule

// File: rtl/apb_fll_if.sv
// apb_fll_if: APB slave bridging to the FLL register port, plus a local lock STATUS register
// ports: clk_i/rstn_i clock and async active-low reset; P* APB slave;
//        fll_req_o/fll_wrn_o/fll_add_o/fll_data_o/fll_ack_i/fll_r_data_i FLL handshake; fll_lock_i async lock
module apb_fll_if
    import apb_fll_if_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      fll_req_o,
    output logic                      fll_wrn_o,
    output logic [1:0]                fll_add_o,
    output logic [31:0]               fll_data_o,
    input  logic                      fll_ack_i,
    input  logic [31:0]               fll_r_data_i,
    input  logic                      fll_lock_i
);
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES) : 8;
    // counter holds cycles already spent in REQ, so this value marks the last allowed one
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES - 1);
    state_t        state, next;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata, status;
    logic          abort, lock_s, lock_d, lost;
    logic          hi, is_fll, is_stat, acc, start, clr, unused_ok;
    sync_2ff u_sync (.clk_i(clk_i), .rstn_i(rstn_i), .d(fll_lock_i), .q(lock_s));
    assign unused_ok = ^PADDR[1:0];
    assign hi        = (PADDR >> 5) == '0;
    assign is_fll    = hi && PADDR[4:2] < FLL_STATUS[4:2];
    assign is_stat   = hi && PADDR[4:2] == FLL_STATUS[4:2];
    assign acc       = PSEL && PENABLE;
    // start from setup or access phase, so a busy FLL (ack still high) is simply retried
    assign start     = state == IDLE && PSEL && is_fll && !fll_ack_i;
    assign clr       = state == IDLE && acc && PWRITE && is_stat && PWDATA[STATUS_LOCK_LOST];
    assign status    = (32'(lock_s) << STATUS_LOCK) | (32'(lost) << STATUS_LOCK_LOST);
    assign fll_req_o = state == REQ;
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) state <= IDLE;
        else         state <= next;
    always_comb begin
        next    = state;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        case (state)
            IDLE: begin
                next    = start ? REQ : IDLE;
                PREADY  = acc && !is_fll;
                PSLVERR = acc && !is_fll && !is_stat;
                PRDATA  = (acc && is_stat && !PWRITE) ? status : '0;
            end
            REQ:  next = fll_ack_i ? DONE : (cnt == TMO ? ERR : REQ);
            DONE: begin
                next   = IDLE;
                PREADY = acc && !abort;
                PRDATA = (acc && !abort && !fll_wrn_o) ? rdata : '0;
            end
            ERR: begin
                next    = IDLE;
                PREADY  = acc && !abort;
                PSLVERR = acc && !abort;
            end
            default: next = IDLE;
        endcase
        if (!rstn_i) {PREADY, PSLVERR, PRDATA} = '0;
    end
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            fll_wrn_o  <= 1'b0;
            fll_add_o  <= '0;
            fll_data_o <= '0;
            rdata      <= '0;
            cnt        <= '0;
            abort      <= 1'b0;
            lock_d     <= 1'b0;
            lost       <= 1'b0;
        end else begin
            lock_d <= lock_s;
            lost   <= (lock_d && !lock_s) || (lost && !clr);
            if (start) begin
                fll_wrn_o  <= PWRITE;
                fll_add_o  <= PADDR[3:2];
                fll_data_o <= PWDATA;
                cnt        <= '0;
                abort      <= 1'b0;
            end else if (state == REQ) begin
                cnt   <= cnt + 1'b1;
                abort <= abort || !PSEL;
                if (fll_ack_i) rdata <= fll_r_data_i;
            end
        end
endmodule

// File: tb/tb_apb_fll_if.sv
// tb_apb_fll_if: scoreboard bench for apb_fll_if with directed APB and FLL-side vectors
module tb_apb_fll_if;
    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } apb_exp_t;
    typedef struct {
        logic        wrn;
        logic [1:0]  add;
        logic [31:0] data;
        int          cycles;
    } fll_exp_t;
    logic        clk = 1'b0, rstn = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0, prdata, fll_data, rd = '0;
    logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0, pready, pslverr;
    logic        fll_req, fll_wrn, fll_ack, lock = 1'b0;
    logic [1:0]  fll_add;
    int          checks = 0, errors = 0, dly = 1, rc = 0, wcnt = 0, fc = 0;
    bit          act = 0;
    logic        fw;
    logic [1:0]  fa;
    logic [31:0] fd;
    apb_exp_t    aq[$];
    fll_exp_t    fq[$];
    apb_fll_if dut (
        .clk_i(clk), .rstn_i(rstn), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
        .PSEL(psel), .PENABLE(penable), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .fll_req_o(fll_req), .fll_wrn_o(fll_wrn), .fll_add_o(fll_add), .fll_data_o(fll_data),
        .fll_ack_i(fll_ack), .fll_r_data_i(rd), .fll_lock_i(lock)
    );
    always #5 clk = ~clk;
    assign fll_ack = fll_req && (rc + 1 >= dly);
    always @(posedge clk) rc <= fll_req ? rc + 1 : 0;
    always @(negedge clk) begin
        apb_exp_t e;
        if (!rstn || !psel) wcnt = 0;
        else if (penable) begin
            if (pready) begin
                checks++;
                if (aq.size() == 0) begin
                    errors++;
                    $display("FAIL apb_unexpected got rdata=%h err=%b", prdata, pslverr);
                end else begin
                    e = aq.pop_front();
                    if (prdata !== e.rdata || pslverr !== e.err || wcnt != e.waits) begin
                        errors++;
                        $display("FAIL %s got rdata=%h err=%b waits=%0d want rdata=%h err=%b waits=%0d",
                                 e.name, prdata, pslverr, wcnt, e.rdata, e.err, e.waits);
                    end
                end
                wcnt = 0;
            end else wcnt++;
        end
    end
    always @(negedge clk) begin
        fll_exp_t f;
        if (fll_req) begin
            if (!act) begin
                act = 1;
                fc  = 0;
                fw  = fll_wrn;
                fa  = fll_add;
                fd  = fll_data;
            end
            fc++;
        end else if (act) begin
            act = 0;
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL fll_unexpected got wrn=%b add=%0d data=%h cycles=%0d", fw, fa, fd, fc);
            end else begin
                f = fq.pop_front();
                if (fw !== f.wrn || fa !== f.add || fd !== f.data || fc != f.cycles) begin
                    errors++;
                    $display("FAIL fll_txn got wrn=%b add=%0d data=%h cycles=%0d want wrn=%b add=%0d data=%h cycles=%0d",
                             fw, fa, fd, fc, f.wrn, f.add, f.data, f.cycles);
                end
            end
        end
    end
    task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, g, e);
        end
    endtask
    task automatic fexp(input logic w, input logic [1:0] a, input logic [31:0] d, input int c);
        fll_exp_t f;
        f.wrn = w; f.add = a; f.data = d; f.cycles = c;
        fq.push_back(f);
    endtask
    task automatic apb(input logic [11:0] a, input logic w, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int ew, input string nm);
        apb_exp_t e;
        bit got = 0;
        e.name = nm; e.rdata = er; e.err = ee; e.waits = ew;
        aq.push_back(e);
        @(posedge clk); #1 psel = 1; penable = 0; paddr = a; pwrite = w; pwdata = wd;
        @(posedge clk); #1 penable = 1;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            got = pready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s got no PREADY want PREADY within 1000 cycles", nm);
            void'(aq.pop_back());
        end
        @(posedge clk); #1 psel = 0; penable = 0;
    endtask
    initial begin
        #12;
        chk("rst_pready", 32'(pready), 0);
        chk("rst_pslverr", 32'(pslverr), 0);
        chk("rst_prdata", prdata, 0);
        chk("rst_fll", {fll_req, fll_wrn, fll_add, 28'(fll_data != 0)}, 0);
        @(posedge clk); #1 rstn = 1;
        #2 chk("idle_psel0", {31'(prdata != 0), pready | pslverr}, 0);
        dly = 1;
        fexp(1, 2, 32'hDEADBEEF, 1);
        apb(12'h008, 1, 32'hDEADBEEF, 0, 0, 1, "wr08_comb_ack");
        dly = 5; rd = 32'h12345678;
        fexp(0, 1, 0, 5);
        apb(12'h004, 0, 0, 32'h12345678, 0, 5, "rd04_ack5");
        dly = 100000;
        fexp(0, 3, 0, 255);
        apb(12'h00C, 0, 0, 0, 1, 255, "rd0c_timeout");
        chk("req_after_timeout", 32'(fll_req), 0);
        apb(12'h020, 0, 0, 0, 1, 0, "oor20_rd");
        apb(12'h024, 1, 32'hFFFFFFFF, 0, 1, 0, "oor24_wr");
        apb(12'h014, 0, 0, 0, 1, 0, "oor14_rd");
        apb(12'h010, 0, 0, 0, 0, 0, "status_init");
        lock = 1;
        repeat (3) @(posedge clk);
        apb(12'h010, 0, 0, 1, 0, 0, "status_locked");
        lock = 0;
        repeat (4) @(posedge clk);
        apb(12'h010, 0, 0, 2, 0, 0, "status_lost");
        apb(12'h030, 1, 2, 0, 1, 0, "oor30_wr_noclr");
        apb(12'h010, 0, 0, 2, 0, 0, "status_kept");
        apb(12'h010, 1, 2, 0, 0, 0, "status_clr_wr");
        apb(12'h010, 0, 0, 0, 0, 0, "status_cleared");
        dly = 4; rd = 32'hCAFEF00D;
        fexp(0, 0, 0, 4);
        @(posedge clk); #1 psel = 1; penable = 0; paddr = 12'h000; pwrite = 0; pwdata = 0;
        @(posedge clk); #1 penable = 1;
        @(posedge clk); #1 psel = 0; penable = 0;
        repeat (8) @(posedge clk);
        dly = 2; rd = 32'h0BADCAFE;
        fexp(0, 0, 0, 2);
        apb(12'h000, 0, 0, 32'h0BADCAFE, 0, 2, "rd00_after_abandon");
        dly = 100000;
        fexp(1, 1, 32'h55AA55AA, 3);
        @(posedge clk); #1 psel = 1; penable = 0; paddr = 12'h004; pwrite = 1; pwdata = 32'h55AA55AA;
        @(posedge clk); #1 penable = 1;
        repeat (3) @(negedge clk);
        #2 rstn = 0;
        #1 chk("midreq_rst_req", 32'(fll_req), 0);
        chk("midreq_rst_fll", {fll_wrn, fll_add, 29'(fll_data != 0)}, 0);
        chk("midreq_rst_apb", {pready, pslverr, 30'(prdata != 0)}, 0);
        psel = 0; penable = 0;
        @(posedge clk); #1 rstn = 1;
        dly = 1;
        fexp(1, 0, 32'hA5A50001, 1);
        apb(12'h000, 1, 32'hA5A50001, 0, 0, 1, "wr00_after_rst");
        repeat (5) @(posedge clk);
        chk("apb_queue_left", aq.size(), 0);
        chk("fll_queue_left", fq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
